// File: rtl/la_operand_loader.sv
// Logic-analyser operand loader: takes 32-bit word writes over the LA bus into the
// A/B operand registers, launches the downstream core and serves its result back.
module la_operand_loader #(
  parameter int N     = 163,
  parameter int WORDS = 6
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic [63:0]    la_data_in,
  input  logic [63:0]    la_oenb,
  output logic [63:0]    la_data_out,
  output logic [N-1:0]   core_a,
  output logic [N-1:0]   core_b,
  output logic           core_start,
  input  logic           core_done,
  input  logic [N-1:0]   core_result
);

  localparam int LAST_W = N - 32 * (WORDS - 1);

  localparam logic [1:0] TGT_A  = 2'b00;
  localparam logic [1:0] TGT_B  = 2'b01;
  localparam logic [1:0] TGT_RD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             strobe_q;
  logic             ack_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             done_q;
  logic [WORDS-1:0] mask_a;
  logic [WORDS-1:0] mask_b;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     res_q;

  logic             busy;
  logic             a_full;
  logic             b_full;
  logic [WORDS-1:0] wr_a;
  logic [WORDS-1:0] wr_b;
  logic             err_set;
  logic             clr;
  logic             go;
  logic             rd_en;
  logic             cap;

  logic             vld_p0;
  logic [31:0]      data_p0;
  logic [2:0]       idx_p0;
  logic [1:0]       tgt_p0;
  logic             idx_ok_p0;
  logic [WORDS-1:0] onehot_p0;
  logic [31:0]      rd_word_p0;
  logic [31:0]      res_word [WORDS];

  // Only the low 38 LA bits carry protocol; the rest is intentionally dropped.
  logic unused_hi;
  assign unused_hi = ^{la_data_in[63:38], la_oenb[63:38]};

  // Stage p0: request decode straight off the LA bus
  assign vld_p0     = (la_data_in[37] != strobe_q) && (la_oenb[37:0] == 38'd0);
  assign data_p0    = la_data_in[31:0];
  assign idx_p0     = la_data_in[34:32];
  assign tgt_p0     = la_data_in[36:35];
  assign idx_ok_p0  = ({29'd0, idx_p0} < 32'(WORDS));
  assign onehot_p0  = WORDS'(1) << idx_p0;
  assign rd_word_p0 = idx_ok_p0 ? res_word[idx_p0] : 32'd0;

  assign busy   = (state_q == S_START) || (state_q == S_WAIT);
  assign a_full = &mask_a;
  assign b_full = &mask_b;

  always_comb begin
    state_d = state_q;
    wr_a    = '0;
    wr_b    = '0;
    err_set = 1'b0;
    clr     = 1'b0;
    go      = 1'b0;
    rd_en   = 1'b0;
    cap     = 1'b0;

    case (state_q)
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          cap     = 1'b1;
          state_d = S_DONE;
        end
      end
      default: ;
    endcase

    if (vld_p0) begin
      case (tgt_p0)
        TGT_A, TGT_B: begin
          if (busy || !idx_ok_p0) begin
            err_set = 1'b1;
          end else begin
            if (tgt_p0 == TGT_A) wr_a = onehot_p0;
            else                 wr_b = onehot_p0;
            state_d = S_IDLE;
          end
        end
        TGT_RD: begin
          rd_en   = 1'b1;
          err_set = !idx_ok_p0;
        end
        default: begin
          // Commands are refused outright while the core owns the operands.
          if (busy) begin
            err_set = 1'b1;
          end else if (idx_p0 == 3'd0) begin
            if (a_full && b_full) begin
              go      = 1'b1;
              state_d = S_START;
            end else begin
              err_set = 1'b1;
            end
          end else if (idx_p0 == 3'd1) begin
            clr     = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_set = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Stage p1: registered control, status and read-back
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      mask_a   <= '0;
      mask_b   <= '0;
      res_q    <= '0;
    end else begin
      strobe_q <= la_data_in[37];
      if (vld_p0) ack_q <= ~ack_q;
      if (rd_en) rdata_q <= rd_word_p0;
      if (clr) err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      if (clr || go) done_q <= 1'b0;
      else if (cap) done_q <= 1'b1;
      if (clr) begin
        mask_a <= '0;
        mask_b <= '0;
      end else begin
        mask_a <= mask_a | wr_a;
        mask_b <= mask_b | wr_b;
      end
      if (cap) res_q <= core_result;
    end
  end

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    localparam int LO = 32 * i;
    localparam int W  = (i == WORDS - 1) ? LAST_W : 32;

    // The last word keeps only the bits that exist in an N-bit operand.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        a_q[LO +: W] <= '0;
        b_q[LO +: W] <= '0;
      end else begin
        if (wr_a[i]) a_q[LO +: W] <= data_p0[W-1:0];
        if (wr_b[i]) b_q[LO +: W] <= data_p0[W-1:0];
      end
    end

    if (W == 32) begin : g_full
      assign res_word[i] = res_q[LO +: 32];
    end else begin : g_part
      assign res_word[i] = {{(32 - W){1'b0}}, res_q[LO +: W]};
    end
  end

  assign core_a      = a_q;
  assign core_b      = b_q;
  assign core_start  = (state_q == S_START);
  assign la_data_out = {26'd0, err_q, b_full, a_full, done_q, busy, ack_q, rdata_q};

endmodule

// File: tb/tb_la_operand_loader.sv
// Randomised and directed bench for la_operand_loader against a word-level
// behavioural model of the LA request protocol.
module tb_la_operand_loader;

  localparam int N     = 163;
  localparam int WORDS = 6;
  localparam int WIDE  = 32 * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic [63:0]    din;
  logic [63:0]    oenb;
  logic [63:0]    dout;
  logic [N-1:0]   core_a;
  logic [N-1:0]   core_b;
  logic [N-1:0]   cres;
  logic           cstart;
  logic           cdone;

  always #5 clk = ~clk;

  la_operand_loader #(.N(N), .WORDS(WORDS)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .la_data_in  (din),
    .la_oenb     (oenb),
    .la_data_out (dout),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_start  (cstart),
    .core_done   (cdone),
    .core_result (cres)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ack_tgls = 0;
  int start_pulses = 0;
  logic prev_ack = 1'b0;

  // model: mode 0 idle, 1 start, 2 wait, 3 done
  int               m_mode;
  logic             m_strobe, m_ack, m_err, m_done;
  logic [31:0]      m_rdata;
  logic [N-1:0]     m_a, m_b, m_res;
  logic [WORDS-1:0] m_ha, m_hb;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] put_w(input logic [N-1:0] v, input int i, input logic [31:0] w);
    logic [WIDE-1:0] t;
    logic [WIDE-1:0] m;
    t = {{(WIDE-N){1'b0}}, v};
    m = {{(WIDE-32){1'b0}}, 32'hFFFF_FFFF} << (32 * i);
    t = (t & ~m) | ({{(WIDE-32){1'b0}}, w} << (32 * i));
    return t[N-1:0];
  endfunction

  function automatic logic [31:0] get_w(input logic [N-1:0] v, input int i);
    logic [WIDE-1:0] t;
    t = {{(WIDE-N){1'b0}}, v} >> (32 * i);
    return t[31:0];
  endfunction

  task automatic model_step();
    int old;
    logic busy, ev;
    int idx;
    logic [1:0] tgt;
    if (rst) begin
      m_mode = 0; m_strobe = 0; m_ack = 0; m_err = 0; m_done = 0;
      m_rdata = 0; m_a = 0; m_b = 0; m_res = 0; m_ha = 0; m_hb = 0;
      return;
    end
    old  = m_mode;
    busy = (old == 1) || (old == 2);
    ev   = (din[37] !== m_strobe) && (oenb[37:0] == 38'd0);
    m_strobe = din[37];
    if (ev) begin
      m_ack = ~m_ack;
      tgt = din[36:35];
      idx = int'(din[34:32]);
      case (tgt)
        2'b00, 2'b01: begin
          if (busy || idx >= WORDS) m_err = 1;
          else begin
            if (tgt == 2'b00) begin m_a = put_w(m_a, idx, din[31:0]); m_ha[idx] = 1'b1; end
            else              begin m_b = put_w(m_b, idx, din[31:0]); m_hb[idx] = 1'b1; end
            m_mode = 0;
          end
        end
        2'b10: begin
          m_rdata = (idx < WORDS) ? get_w(m_res, idx) : 32'd0;
          if (idx >= WORDS) m_err = 1;
        end
        default: begin
          if (busy) m_err = 1;
          else if (idx == 0) begin
            if (&m_ha && &m_hb) begin m_mode = 1; m_done = 0; end
            else m_err = 1;
          end else if (idx == 1) begin
            m_ha = 0; m_hb = 0; m_err = 0; m_done = 0; m_mode = 0;
          end else m_err = 1;
        end
      endcase
    end
    if (old == 1) m_mode = 2;
    else if (old == 2 && cdone) begin m_res = cres; m_done = 1; m_mode = 3; end
  endtask

  task automatic step();
    logic [63:0] exp;
    logic b;
    @(posedge clk);
    model_step();
    #1;
    b   = (m_mode == 1) || (m_mode == 2);
    exp = {26'd0, m_err, &m_hb, &m_ha, m_done, b, m_ack, m_rdata};
    chk("la_data_out", dout, exp);
    chk("core_a", core_a, m_a);
    chk("core_b", core_b, m_b);
    chk("core_start", cstart, m_mode == 1);
    if (dout[32] !== prev_ack) ack_tgls++;
    prev_ack = dout[32];
    if (cstart) start_pulses++;
  endtask

  task automatic req(input logic [1:0] tgt, input logic [2:0] idx, input logic [31:0] d);
    din[31:0]  = d;
    din[34:32] = idx;
    din[36:35] = tgt;
    din[37]    = ~din[37];
    step();
  endtask

  task automatic fill(input logic skip_b3);
    for (int i = 0; i < WORDS; i++) req(2'b00, 3'(i), 32'(32'h1111_1111 * (i + 1)));
    for (int i = 0; i < WORDS; i++)
      if (!(skip_b3 && i == 3)) req(2'b01, 3'(i), 32'hA000_0000 | 32'(i));
  endtask

  logic [31:0] exp_rd [WORDS];
  int t0, s0;

  initial begin
    exp_rd[0] = 32'h2468ACE0; exp_rd[1] = 32'h13579BDF; exp_rd[2] = 32'h89ABCDEF;
    exp_rd[3] = 32'h01234567; exp_rd[4] = 32'hDEADBEEF; exp_rd[5] = 32'h0000_0005;
    rst = 1'b1; din = '0; oenb = '0; cdone = 1'b0; cres = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_dout", dout, 64'd0);
    chk("rst_core_a", core_a, '0);

    // full operand load: six acks for A, top three bits of A from 0x66666666
    t0 = ack_tgls;
    for (int i = 0; i < WORDS; i++) req(2'b00, 3'(i), 32'(32'h1111_1111 * (i + 1)));
    chk("ack_count_a", 32'(ack_tgls - t0), 32'd6);
    for (int i = 0; i < WORDS; i++) req(2'b01, 3'(i), 32'hA000_0000 | 32'(i));
    chk("a_full", dout[35], 1'b1);
    chk("b_full", dout[36], 1'b1);
    chk("a_top_bits", core_a[162:160], 3'b110);

    // start with B word 3 missing is refused
    req(2'b11, 3'd1, 32'd0);
    fill(1'b1);
    s0 = start_pulses;
    req(2'b11, 3'd0, 32'd0);
    step();
    chk("start_refused_err", dout[37], 1'b1);
    chk("start_refused_busy", dout[33], 1'b0);
    chk("start_refused_pulses", 32'(start_pulses - s0), 32'd0);

    // full load and run
    req(2'b11, 3'd1, 32'd0);
    fill(1'b0);
    s0 = start_pulses;
    req(2'b11, 3'd0, 32'd0);
    chk("start_high", cstart, 1'b1);
    chk("start_busy", dout[33], 1'b1);
    step();
    chk("start_one_cycle", cstart, 1'b0);
    step();
    req(2'b00, 3'd2, 32'hFFFF_FFFF);
    chk("wait_write_kept", core_a[95:64], 32'h3333_3333);
    chk("wait_write_err", dout[37], 1'b1);
    step();
    cres = {3'h5, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0};
    cdone = 1'b1;
    step();
    cdone = 1'b0;
    chk("run_done", dout[34], 1'b1);
    chk("run_busy", dout[33], 1'b0);
    chk("run_pulses", 32'(start_pulses - s0), 32'd1);
    for (int i = 0; i < WORDS; i++) begin
      req(2'b10, 3'(i), 32'd0);
      chk("read_word", dout[31:0], exp_rd[i]);
    end
    req(2'b10, 3'd6, 32'd0);
    chk("read_oob", dout[31:0], 32'd0);

    // masked strobe is not an event
    t0 = ack_tgls;
    oenb[37] = 1'b1;
    din[36:35] = 2'b11; din[34:32] = 3'd0; din[37] = ~din[37];
    step();
    oenb = '0;
    step();
    chk("masked_no_ack", 32'(ack_tgls - t0), 32'd0);
    chk("masked_no_busy", dout[33], 1'b0);

    // reset during WAIT abandons the run
    req(2'b11, 3'd0, 32'd0);
    step();
    chk("pre_rst_busy", dout[33], 1'b1);
    rst = 1'b1; din[37] = 1'b0;
    step();
    rst = 1'b0;
    cres = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    cdone = 1'b1;
    step();
    cdone = 1'b0;
    chk("rst_wait_dout", dout, 64'd0);
    chk("rst_wait_core_b", core_b, '0);

    // randomised traffic
    for (int c = 0; c < 4000; c++) begin
      int p;
      rst   = ($urandom_range(0, 199) == 0);
      cdone = ($urandom_range(0, 3) == 0);
      cres  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      oenb  = '0;
      if ($urandom_range(0, 15) == 0) oenb[$urandom_range(0, 63)] = 1'b1;
      if (rst) din[37] = 1'b0;
      else if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, 9);
        din[31:0] = $urandom();
        if (p < 3)      begin din[36:35] = 2'b00; din[34:32] = 3'($urandom_range(0, 6)); end
        else if (p < 6) begin din[36:35] = 2'b01; din[34:32] = 3'($urandom_range(0, 6)); end
        else if (p < 8) begin din[36:35] = 2'b10; din[34:32] = 3'($urandom_range(0, 7)); end
        else begin
          din[36:35] = 2'b11;
          if ($urandom_range(0, 3) != 0) din[34:32] = 3'd0;
          else if ($urandom_range(0, 1) == 1) din[34:32] = 3'd1;
          else din[34:32] = 3'($urandom_range(2, 7));
        end
        din[37] = ~din[37];
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/la_operand_loader.md
LA_OPERAND_LOADER -- requirements
Module: la_operand_loader

Interface
REQ-001 Parameter N, default 163, operand/result width in bits.
REQ-002 Parameter WORDS, default 6, 32-bit words per operand, equal to ceil(N/32).
REQ-003 wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 la_data_in  in  64  [31:0] data word, [34:32] word index, [36:35] target (00=A, 01=B, 10=result read, 11=command), [37] strobe (toggle), [63:38] unused.
REQ-006 la_oenb  in  64  per-bit LA enable, active-low; bits [37:0] must all be 0 for a strobe to be honoured.
REQ-007 la_data_out  out  64  [31:0] read data, [32] ack (toggle), [33] busy, [34] done, [35] a_full, [36] b_full, [37] err, [63:38] zero.
REQ-008 core_a, core_b  out  N each  operand registers A and B for the downstream BEC core.
REQ-009 core_start  out  1  one-cycle start pulse to the core.
REQ-010 core_done  in  1  one-cycle completion pulse from the core.
REQ-011 core_result  in  N  core result, valid in the cycle core_done is high.

Function
REQ-012 Strobe event SHALL be detected when la_data_in[37] differs from its registered copy strobe_q and la_oenb[37:0]==0; strobe_q SHALL update every cycle.
REQ-013 Each strobe event SHALL toggle ack (la_data_out[32]) exactly one cycle later, whether or not the request is accepted.
REQ-014 States: IDLE, START, WAIT, DONE; reset state IDLE.
REQ-015 In IDLE or DONE, target A/B write SHALL store data into word[index] of A/B (bits 32*i+31:32*i) and set mask bit i; in word WORDS-1 only bits [N-1-32*(WORDS-1):0] are stored (3 bits for N=163), upper bits ignored.
REQ-016 A write to index >= WORDS SHALL store nothing and set err.
REQ-017 a_full/b_full SHALL be 1 exactly when the corresponding WORDS-bit mask is all ones.
REQ-018 Command index 0 (start): if a_full and b_full, go to START, clear done; else set err and stay.
REQ-019 Command index 1 (clear): clear both masks, err and done, go to IDLE; A/B contents are not zeroed; any other command index sets err.
REQ-020 START SHALL assert core_start for exactly one cycle, then move to WAIT; busy=1 in START and WAIT.
REQ-021 WAIT: on core_done, capture core_result into result register, set done, go to DONE; core_done in any other state SHALL be ignored.
REQ-022 Any A/B write or command received in START or WAIT SHALL be ignored and set err (ack still toggles); a clear command is also ignored in START/WAIT.
REQ-023 Strobe event and core_done in the same WAIT cycle: result captured, request ignored with err.
REQ-024 Result read (target 10) SHALL place result word[index] on la_data_out[31:0] in the same cycle ack toggles; unused upper bits of the last word read as 0; index >= WORDS returns 0 and sets err; reads are legal in every state and return the last captured result.
REQ-025 err is sticky until clear command or reset; writes in DONE return to IDLE semantics (state IDLE) while keeping done=1 until next start.
REQ-026 core_a/core_b SHALL be driven directly from the A/B registers and be stable while busy=1.

Reset
REQ-027 On wb_rst_i: state IDLE; A, B, result, masks, strobe_q := la_data_in[37] value 0, ack, busy, done, err, core_start, la_data_out all 0.
REQ-028 Reset asserted in WAIT SHALL abandon the operation; a later core_done SHALL be ignored and done stays 0.

Verification
REQ-029 Write A words 0..5 = 0x11111111..0x66666666, B similarly 0xA..; -> a_full=b_full=1, core_a[162:160]=3'b110, six ack toggles.
REQ-030 Start command with B word 3 missing -> err=1, core_start never pulses, state IDLE.
REQ-031 Full load, start -> core_start high exactly 1 cycle, busy=1; core_done with result 0x5_DEADBEEF_... -> done=1, busy=0; reads of index 0..5 return matching words, index 5 upper 29 bits 0.
REQ-032 Write to A index 2 during WAIT -> ack toggles, err=1, core_a unchanged.
REQ-033 Strobe toggled with la_oenb[37]=1 -> no ack toggle, no state change.
REQ-034 wb_rst_i pulsed in WAIT, then core_done -> done=0, all outputs 0, masks 0.
